// File: rtl/cam_encoder.sv
// CAM result encoder: walks captured match lines in ascending index order.
// Optional match counter built when CAM_ENCODER_COUNT_EN is defined.
module cam_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  search_i,
    input  logic [DEPTH-1:0]      match_i,
    input  logic                  next_i,
    output logic                  valid_o,
    output logic                  found_o,
    output logic [ADDR_WIDTH-1:0] index_o,
    output logic                  multi_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    if (DATA_WIDTH < 1 || DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_cfg
        $error("cam_encoder: inconsistent DATA_WIDTH/ADDR_WIDTH/DEPTH");
    end

    typedef enum logic {
        S_IDLE,
        S_RESULT
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DEPTH-1:0]      r_pending;
    logic [DEPTH-1:0]      w_pending_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic [DEPTH-1:0]      w_rest;
    logic [ADDR_WIDTH-1:0] w_index;

    // Pending & (pending-1) drops the lowest set bit: the retire value.
    assign w_rest = r_pending & (r_pending - DEPTH'(1));

    always_comb begin
        w_index = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (r_pending[k]) begin
                w_index = ADDR_WIDTH'(k);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_done_nxt    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (search_i) begin
                    w_pending_nxt = match_i;
                    w_state_nxt   = S_RESULT;
                end
            end
            S_RESULT: begin
                if (next_i) begin
                    w_pending_nxt = w_rest;
                    if (w_rest == '0) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign valid_o = (r_state == S_RESULT);
    assign busy_o  = (r_state == S_RESULT);
    assign found_o = valid_o & (|r_pending);
    assign multi_o = valid_o & (|w_rest);
    assign index_o = valid_o ? w_index : '0;
    assign done_o  = r_done;

`ifdef CAM_ENCODER_COUNT_EN
    logic [ADDR_WIDTH:0] r_count;
    logic [ADDR_WIDTH:0] w_popcnt;

    always_comb begin
        w_popcnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_popcnt = w_popcnt + (ADDR_WIDTH + 1)'(match_i[k]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (r_state == S_IDLE && search_i) begin
            r_count <= w_popcnt;
        end
    end

    assign count_o = r_count;
`else
    assign count_o = '0;
`endif

endmodule

// File: tb/tb_cam_encoder.sv
// Directed self-checking bench for cam_encoder.
// Count expectations follow CAM_ENCODER_COUNT_EN.
module tb_cam_encoder;

    localparam int AW = 5;
    localparam int DP = 1 << AW;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          search_i;
    logic [DP-1:0] match_i;
    logic          next_i;
    logic          valid_o;
    logic          found_o;
    logic [AW-1:0] index_o;
    logic          multi_o;
    logic          done_o;
    logic          busy_o;
    logic [AW:0]   count_o;

    int n_checks = 0;
    int n_errors = 0;

    cam_encoder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(AW),
        .DEPTH     (DP)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .search_i(search_i),
        .match_i (match_i),
        .next_i  (next_i),
        .valid_o (valid_o),
        .found_o (found_o),
        .index_o (index_o),
        .multi_o (multi_o),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .count_o (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input int n);
`ifdef CAM_ENCODER_COUNT_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i  = 1'b1;
        search_i = 1'b0;
        match_i  = '0;
        next_i   = 1'b0;
        step();
        step();
        reset_i = 1'b0;
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_found", 32'(found_o), 0);
        chk("rst_multi", 32'(multi_o), 0);
        chk("rst_done",  32'(done_o),  0);
        chk("rst_busy",  32'(busy_o),  0);
        chk("rst_index", 32'(index_o), 0);
        chk("rst_count", 32'(count_o), 0);

        // single hit
        search_i = 1'b1;
        match_i  = 32'h0000_0100;
        step();
        search_i = 1'b0;
        chk("sh_valid", 32'(valid_o), 1);
        chk("sh_found", 32'(found_o), 1);
        chk("sh_index", 32'(index_o), 8);
        chk("sh_multi", 32'(multi_o), 0);
        chk("sh_count", 32'(count_o), cexp(1));
        chk("sh_busy",  32'(busy_o),  1);
        next_i = 1'b1;
        step();
        next_i = 1'b0;
        chk("sh_done",   32'(done_o),  1);
        chk("sh_valid0", 32'(valid_o), 0);
        step();
        chk("sh_done0",  32'(done_o),  0);
        chk("sh_count_hold", 32'(count_o), cexp(1));

        // multi-hit walk with next held high
        search_i = 1'b1;
        match_i  = 32'h8000_0011;
        step();
        search_i = 1'b0;
        chk("mh_idx0",   32'(index_o), 0);
        chk("mh_multi0", 32'(multi_o), 1);
        chk("mh_count",  32'(count_o), cexp(3));
        next_i = 1'b1;
        step();
        chk("mh_idx1",   32'(index_o), 4);
        chk("mh_multi1", 32'(multi_o), 1);
        chk("mh_valid1", 32'(valid_o), 1);
        chk("mh_done1",  32'(done_o),  0);
        step();
        chk("mh_idx2",   32'(index_o), 31);
        chk("mh_multi2", 32'(multi_o), 0);
        chk("mh_count2", 32'(count_o), cexp(3));
        step();
        next_i = 1'b0;
        chk("mh_valid3", 32'(valid_o), 0);
        chk("mh_done3",  32'(done_o),  1);
        step();
        chk("mh_done4",  32'(done_o),  0);

        // zero match
        search_i = 1'b1;
        match_i  = '0;
        step();
        search_i = 1'b0;
        chk("zm_valid", 32'(valid_o), 1);
        chk("zm_found", 32'(found_o), 0);
        chk("zm_index", 32'(index_o), 0);
        chk("zm_multi", 32'(multi_o), 0);
        chk("zm_count", 32'(count_o), cexp(0));
        next_i = 1'b1;
        step();
        next_i = 1'b0;
        chk("zm_done",  32'(done_o),  1);
        chk("zm_valid0", 32'(valid_o), 0);
        chk("zm_busy0", 32'(busy_o),  0);

        // hold and ignore search while in RESULT
        search_i = 1'b1;
        match_i  = 32'h0000_0006;
        step();
        match_i  = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hi_index", 32'(index_o), 1);
            chk("hi_count", 32'(count_o), cexp(2));
            chk("hi_busy",  32'(busy_o),  1);
            chk("hi_multi", 32'(multi_o), 1);
        end
        search_i = 1'b0;
        next_i   = 1'b1;
        step();
        next_i = 1'b0;
        chk("hi_idx2",  32'(index_o), 2);
        chk("hi_multi2", 32'(multi_o), 0);

        // simultaneous search and next on last result
        search_i = 1'b1;
        match_i  = 32'h0000_00FF;
        next_i   = 1'b1;
        step();
        search_i = 1'b0;
        next_i   = 1'b0;
        chk("sim_valid", 32'(valid_o), 0);
        chk("sim_done",  32'(done_o),  1);
        step();
        chk("sim_valid2", 32'(valid_o), 0);
        chk("sim_busy2",  32'(busy_o),  0);
        chk("sim_count",  32'(count_o), cexp(2));

        // next in IDLE is ignored
        next_i = 1'b1;
        step();
        next_i = 1'b0;
        chk("in_done",  32'(done_o),  0);
        chk("in_valid", 32'(valid_o), 0);

        // reset mid-walk
        search_i = 1'b1;
        match_i  = 32'h0000_000F;
        step();
        search_i = 1'b0;
        next_i   = 1'b1;
        step();
        next_i = 1'b0;
        chk("rm_idx1", 32'(index_o), 1);
        reset_i = 1'b1;
        next_i  = 1'b1;
        step();
        reset_i = 1'b0;
        next_i  = 1'b0;
        chk("rm_valid", 32'(valid_o), 0);
        chk("rm_found", 32'(found_o), 0);
        chk("rm_index", 32'(index_o), 0);
        chk("rm_multi", 32'(multi_o), 0);
        chk("rm_done",  32'(done_o),  0);
        chk("rm_busy",  32'(busy_o),  0);
        chk("rm_count", 32'(count_o), 0);
        step();
        chk("rm_done2", 32'(done_o), 0);
        search_i = 1'b1;
        match_i  = 32'h0000_0002;
        step();
        search_i = 1'b0;
        chk("rm_new_idx",   32'(index_o), 1);
        chk("rm_new_found", 32'(found_o), 1);
        chk("rm_new_count", 32'(count_o), cexp(1));

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
